// File: rtl/nem_ohmux_sel_ctrl.sv
// Round-robin arbiter and break-before-make sequencer for a NEM one-hot relay mux.
// Select lines are only closed from an all-open mux, and grants wait out the relay pull-in time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | all relays open, arbitrating pending requests
// ST_CLOSE | winner's select closed, waiting T_CLOSE for pull-in
// ST_GRANT | path settled, grant held until the winner drops its request
// ST_OPEN  | all relays open, waiting T_OPEN for release
module nem_ohmux_sel_ctrl #(
    parameter int N_REQ   = 4,
    parameter int T_CLOSE = 4,
    parameter int T_OPEN  = 3,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] S,
    output logic [N_REQ-1:0] GNT,
    output logic             BUSY
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(T_CLOSE - 1);
    localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(T_OPEN - 1);
    localparam logic [IDX_W-1:0] RR_INIT    = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE        = N_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLOSE,
        ST_GRANT,
        ST_OPEN
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_REQ-1:0] s_nxt, gnt_nxt;
    logic [IDX_W-1:0] rr_last, rr_nxt;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic             held;

    // rr_last doubles as the current winner once a select has been closed.
    assign held = REQ[rr_last];
    assign BUSY = (state != ST_IDLE);

    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!win_vld && REQ[(int'(rr_last) + i) % N_REQ]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((int'(rr_last) + i) % N_REQ);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            S       <= '0;
            GNT     <= '0;
            rr_last <= RR_INIT;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            S       <= s_nxt;
            GNT     <= gnt_nxt;
            rr_last <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        s_nxt     = S;
        gnt_nxt   = GNT;
        rr_nxt    = rr_last;
        case (state)
            ST_IDLE: begin
                s_nxt   = '0;
                gnt_nxt = '0;
                if (win_vld) begin
                    s_nxt     = ONE << win_idx;
                    rr_nxt    = win_idx;
                    cnt_nxt   = CLOSE_LOAD;
                    state_nxt = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                if (!held) begin
                    s_nxt     = '0;
                    gnt_nxt   = '0;
                    cnt_nxt   = OPEN_LOAD;
                    state_nxt = ST_OPEN;
                end else if (cnt == '0) begin
                    gnt_nxt   = S;
                    state_nxt = ST_GRANT;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_GRANT: begin
                if (!held) begin
                    s_nxt     = '0;
                    gnt_nxt   = '0;
                    cnt_nxt   = OPEN_LOAD;
                    state_nxt = ST_OPEN;
                end
            end
            ST_OPEN: begin
                s_nxt   = '0;
                gnt_nxt = '0;
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                s_nxt     = '0;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Scoreboard bench for nem_ohmux_sel_ctrl: expected output transitions (edge, S, GNT, BUSY)
// are queued by the stimulus and popped by per-instance monitors whenever the outputs change.
module tb_nem_ohmux_sel_ctrl;

    typedef struct {
        int       cyc;
        logic [3:0] s;
        logic [3:0] g;
        logic       b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = '0, req_b = '0;
    logic [3:0] s_a, gnt_a, s_b, gnt_b;
    logic       busy_a, busy_b;

    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;
    ev_t  qa[$];
    ev_t  qb[$];
    logic [8:0] prev_a = '0, prev_b = '0;

    nem_ohmux_sel_ctrl #(.N_REQ(4), .T_CLOSE(4), .T_OPEN(3), .CNT_W(8)) dut_a (
        .CLK(clk), .RST(rst), .REQ(req_a), .S(s_a), .GNT(gnt_a), .BUSY(busy_a)
    );

    nem_ohmux_sel_ctrl #(.N_REQ(4), .T_CLOSE(1), .T_OPEN(1), .CNT_W(8)) dut_b (
        .CLK(clk), .RST(rst), .REQ(req_b), .S(s_b), .GNT(gnt_b), .BUSY(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic compare_ev(input string tag, input ev_t exp, input ev_t act);
        checks++;
        if (exp.cyc != act.cyc || exp.s !== act.s || exp.g !== act.g || exp.b !== act.b) begin
            failures++;
            $display("FAIL %s event: got edge=%0d S=%b GNT=%b BUSY=%b, expected edge=%0d S=%b GNT=%b BUSY=%b",
                     tag, act.cyc, act.s, act.g, act.b, exp.cyc, exp.s, exp.g, exp.b);
        end
    endtask

    task automatic check_inv(input string tag, input logic [3:0] s, input logic [3:0] g);
        checks++;
        if (!$onehot0(s) || !$onehot0(g) || (g != 4'b0 && g != s)) begin
            failures++;
            $display("FAIL %s invariant: got S=%b GNT=%b, required onehot0 with GNT==S or GNT==0",
                     tag, s, g);
        end
    endtask

    always @(negedge clk) begin
        ev_t act;
        act = '{edge_cnt, s_a, gnt_a, busy_a};
        check_inv("a", s_a, gnt_a);
        if ({s_a, gnt_a, busy_a} !== prev_a) begin
            prev_a = {s_a, gnt_a, busy_a};
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a unexpected: got edge=%0d S=%b GNT=%b BUSY=%b, expected no change",
                         act.cyc, act.s, act.g, act.b);
            end else begin
                compare_ev("a", qa.pop_front(), act);
            end
        end
    end

    always @(negedge clk) begin
        ev_t act;
        act = '{edge_cnt, s_b, gnt_b, busy_b};
        check_inv("b", s_b, gnt_b);
        if ({s_b, gnt_b, busy_b} !== prev_b) begin
            prev_b = {s_b, gnt_b, busy_b};
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b unexpected: got edge=%0d S=%b GNT=%b BUSY=%b, expected no change",
                         act.cyc, act.s, act.g, act.b);
            end else begin
                compare_ev("b", qb.pop_front(), act);
            end
        end
    end

    task automatic push_a(input int c, input logic [3:0] s, input logic [3:0] g, input logic b);
        qa.push_back('{c, s, g, b});
    endtask

    task automatic push_b(input int c, input logic [3:0] s, input logic [3:0] g, input logic b);
        qb.push_back('{c, s, g, b});
    endtask

    task automatic wait_edge(input int target);
        repeat (target - edge_cnt) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int e0, e, s_e, g;
        logic [3:0] oh;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1 and 2: single grant, then handover to a pending requester.
        req_a = 4'b0001;
        e0 = edge_cnt + 1;
        push_a(e0,     4'b0001, 4'b0000, 1'b1);
        push_a(e0 + 4, 4'b0001, 4'b0001, 1'b1);
        wait_edge(e0 + 5);
        req_a = 4'b0010;
        e = e0 + 6;
        push_a(e,     4'b0000, 4'b0000, 1'b1);
        push_a(e + 3, 4'b0000, 4'b0000, 1'b0);
        push_a(e + 4, 4'b0010, 4'b0000, 1'b1);
        push_a(e + 8, 4'b0010, 4'b0010, 1'b1);
        wait_edge(e + 9);
        req_a = 4'b0000;
        push_a(e + 10, 4'b0000, 4'b0000, 1'b1);
        push_a(e + 13, 4'b0000, 4'b0000, 1'b0);
        wait_edge(e + 15);

        // Quiet reset while idle restores rr_last so input 0 leads the rotation.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 3: all requesting, each holder drops for one cycle after its grant.
        req_a = 4'b1111;
        s_e = edge_cnt + 1;
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << (i % 4);
            push_a(s_e,     oh,      4'b0000, 1'b1);
            push_a(s_e + 4, oh,      oh,      1'b1);
            push_a(s_e + 5, 4'b0000, 4'b0000, 1'b1);
            push_a(s_e + 8, 4'b0000, 4'b0000, 1'b0);
            wait_edge(s_e + 4);
            if (i < 4) begin
                req_a = 4'b1111 & ~oh;
                @(negedge clk);
                req_a = 4'b1111;
                s_e = s_e + 9;
            end else begin
                req_a = 4'b0000;
            end
        end
        wait_edge(s_e + 10);

        // 4: abort during CLOSE.
        req_a = 4'b0100;
        e0 = edge_cnt + 1;
        push_a(e0,     4'b0100, 4'b0000, 1'b1);
        push_a(e0 + 2, 4'b0000, 4'b0000, 1'b1);
        push_a(e0 + 5, 4'b0000, 4'b0000, 1'b0);
        wait_edge(e0 + 1);
        req_a = 4'b0000;
        wait_edge(e0 + 8);

        // 5: asynchronous reset mid-GRANT.
        req_a = 4'b1000;
        e0 = edge_cnt + 1;
        push_a(e0,     4'b1000, 4'b0000, 1'b1);
        push_a(e0 + 4, 4'b1000, 4'b1000, 1'b1);
        wait_edge(e0 + 5);
        push_a(e0 + 6, 4'b0000, 4'b0000, 1'b0);
        #2;
        rst   = 1'b1;
        req_a = 4'b0000;
        #1;
        checks++;
        if (s_a !== 4'b0000 || gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got S=%b GNT=%b BUSY=%b, expected S=0000 GNT=0000 BUSY=0",
                     s_a, gnt_a, busy_a);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        req_a = 4'b1001;
        e0 = edge_cnt + 1;
        push_a(e0,     4'b0001, 4'b0000, 1'b1);
        push_a(e0 + 4, 4'b0001, 4'b0001, 1'b1);
        wait_edge(e0 + 5);
        req_a = 4'b0000;
        push_a(e0 + 6, 4'b0000, 4'b0000, 1'b1);
        push_a(e0 + 9, 4'b0000, 4'b0000, 1'b0);
        wait_edge(e0 + 11);

        // 6: minimum timings on the second instance.
        req_b = 4'b0011;
        e0 = edge_cnt + 1;
        push_b(e0,     4'b0001, 4'b0000, 1'b1);
        push_b(e0 + 1, 4'b0001, 4'b0001, 1'b1);
        wait_edge(e0 + 2);
        req_b = 4'b0010;
        g = e0 + 3;
        push_b(g,     4'b0000, 4'b0000, 1'b1);
        push_b(g + 1, 4'b0000, 4'b0000, 1'b0);
        push_b(g + 2, 4'b0010, 4'b0000, 1'b1);
        push_b(g + 3, 4'b0010, 4'b0010, 1'b1);
        wait_edge(g + 4);
        req_b = 4'b0000;
        push_b(g + 5, 4'b0000, 4'b0000, 1'b1);
        push_b(g + 6, 4'b0000, 4'b0000, 1'b0);
        wait_edge(g + 9);

        checks++;
        if (qa.size() != 0) begin
            failures++;
            $display("FAIL a drain: got %0d pending events, expected 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            failures++;
            $display("FAIL b drain: got %0d pending events, expected 0", qb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
